// File: rtl/dmem_responder.sv
// Data-memory slave for the riscv32i load/store path: one request at a time, a
// programmable number of wait states, little-endian byte-addressed access with load extension.
module dmem_responder #(
    parameter int unsigned MEM_SIZE = 4096,
    parameter int unsigned LATENCY  = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_error
);

    localparam int unsigned ADDR_W    = $clog2(MEM_SIZE);
    localparam int unsigned WORDS     = MEM_SIZE / 4;
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);
    localparam logic [3:0]  LAT       = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [2:0] f_size(input logic [1:0] size_code);
        case (size_code)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // The end address is formed in 33 bits so an access near 2^32 cannot wrap into range.
    function automatic logic f_req_error(input logic write, input logic [2:0] funct3,
                                         input logic [31:0] addr);
        logic        bad_op;
        logic        misaligned;
        logic [32:0] end_addr;
        bad_op     = write ? (funct3 > 3'd2)
                           : ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
        misaligned = ((funct3[1:0] == 2'd1) && addr[0]) ||
                     ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'd0));
        end_addr   = {1'b0, addr} + {30'd0, f_size(funct3[1:0])};
        return bad_op || misaligned || (end_addr > MEM_LIMIT);
    endfunction

    function automatic logic [31:0] f_load_extend(input logic [2:0] funct3, input logic [31:0] lane);
        case (funct3)
            3'd0:    return {{24{lane[7]}}, lane[7:0]};
            3'd1:    return {{16{lane[15]}}, lane[15:0]};
            3'd2:    return lane;
            3'd4:    return {24'd0, lane[7:0]};
            3'd5:    return {16'd0, lane[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_write;
    logic [2:0]          r_funct3;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_error;
    logic [31:0]         r_mem [WORDS];

    logic                w_accept;
    logic                w_access;
    logic                w_store;
    logic                w_op_write;
    logic [2:0]          w_op_funct3;
    logic [31:0]         w_op_addr;
    logic [31:0]         w_op_wdata;
    logic                w_op_error;
    logic [ADDR_W-3:0]   w_word_idx;
    logic [4:0]          w_lane_shift;
    logic [3:0]          w_byte_en;
    logic [31:0]         w_store_data;
    logic [31:0]         w_load_lane;
    logic [31:0]         w_load_data;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid && !i_reset;

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = LAT;
                    w_state_nxt = (LAT == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (i_resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // With zero wait states the access happens on the acceptance edge, before capture.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_op_write  = i_req_write;
            w_op_funct3 = i_req_funct3;
            w_op_addr   = i_req_addr;
            w_op_wdata  = i_req_wdata;
        end else begin
            w_op_write  = r_write;
            w_op_funct3 = r_funct3;
            w_op_addr   = r_addr;
            w_op_wdata  = r_wdata;
        end
    end

    assign w_access     = !i_reset && (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
    assign w_op_error   = f_req_error(w_op_write, w_op_funct3, w_op_addr);
    assign w_store      = w_access && w_op_write && !w_op_error;
    assign w_word_idx   = w_op_addr[ADDR_W-1:2];
    assign w_lane_shift = {w_op_addr[1:0], 3'd0};
    assign w_store_data = w_op_wdata << w_lane_shift;
    assign w_load_lane  = r_mem[w_word_idx] >> w_lane_shift;
    assign w_load_data  = (w_op_write || w_op_error) ? 32'd0 : f_load_extend(w_op_funct3, w_load_lane);

    // Byte-lane enables for stores; legal halfword and word accesses never straddle a word.
    always_comb begin
        w_byte_en = 4'b0000;
        case (w_op_funct3[1:0])
            2'd0:    w_byte_en = 4'b0001 << w_op_addr[1:0];
            2'd1:    w_byte_en = 4'b0011 << w_op_addr[1:0];
            default: w_byte_en = 4'b1111;
        endcase
    end

    // Control state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request capture; fields are only loaded in IDLE so later req_valid pulses cannot disturb them.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
        end else if (w_accept) begin
            r_write  <= i_req_write;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
        end else begin
            r_write  <= r_write;
            r_funct3 <= r_funct3;
            r_addr   <= r_addr;
            r_wdata  <= r_wdata;
        end
    end

    // Response data is loaded on the edge entering RESP and held until the next access.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_resp_rdata <= 32'd0;
            r_resp_error <= 1'b0;
        end else if (w_access) begin
            r_resp_rdata <= w_load_data;
            r_resp_error <= w_op_error;
        end else begin
            r_resp_rdata <= r_resp_rdata;
            r_resp_error <= r_resp_error;
        end
    end

    // Storage array; deliberately untouched by reset.
    always_ff @(posedge i_clock) begin
        if (w_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= w_store_data[8*i +: 8];
                end
            end
        end
    end

    assign o_req_ready  = (r_state == ST_IDLE) && !i_reset;
    assign o_resp_valid = (r_state == ST_RESP);
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_error = r_resp_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array reference model predicts each response,
// a monitor checks data, error, latency and hold stability; a second instance covers reset abort.
module tb_dmem_responder;

    localparam int unsigned MEM_SIZE = 4096;
    localparam int unsigned LAT_A    = 1;
    localparam int unsigned LAT_B    = 4;

    typedef struct {
        bit [31:0] rd;
        bit        er;
        int        acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, req_valid_a, req_ready_a, req_write_a, resp_valid_a, resp_ready_a, resp_error_a;
    logic [2:0]  req_funct3_a;
    logic [31:0] req_addr_a, req_wdata_a, resp_rdata_a;
    logic        rst_b, req_valid_b, req_ready_b, req_write_b, resp_valid_b, resp_ready_b, resp_error_b;
    logic [2:0]  req_funct3_b;
    logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;

    dmem_responder #(.MEM_SIZE(MEM_SIZE), .LATENCY(LAT_A)) u_dut_a (
        .i_clock(clk), .i_reset(rst_a), .i_req_valid(req_valid_a), .o_req_ready(req_ready_a),
        .i_req_write(req_write_a), .i_req_funct3(req_funct3_a), .i_req_addr(req_addr_a),
        .i_req_wdata(req_wdata_a), .o_resp_valid(resp_valid_a), .i_resp_ready(resp_ready_a),
        .o_resp_rdata(resp_rdata_a), .o_resp_error(resp_error_a)
    );

    dmem_responder #(.MEM_SIZE(MEM_SIZE), .LATENCY(LAT_B)) u_dut_b (
        .i_clock(clk), .i_reset(rst_b), .i_req_valid(req_valid_b), .o_req_ready(req_ready_b),
        .i_req_write(req_write_b), .i_req_funct3(req_funct3_b), .i_req_addr(req_addr_b),
        .i_req_wdata(req_wdata_b), .o_resp_valid(resp_valid_b), .i_resp_ready(resp_ready_b),
        .o_resp_rdata(resp_rdata_b), .o_resp_error(resp_error_b)
    );

    int        n_checks = 0;
    int        n_errors = 0;
    int        cyc = 0;
    int        rr_mode = 2;      // 0 random, 1 hold low, 2 always high
    int        last_hs_a = -1;
    int        last_acc_a = -1;
    bit        have_a = 1'b0;
    exp_t      cur_a;
    exp_t      q_a[$];
    bit [7:0]  mem_m [MEM_SIZE];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no DUT event, expected one within the cycle budget", name);
    endtask

    // Reference model: byte array plus plain arithmetic on sizes and signed values.
    function automatic void model_access(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                                         input bit [31:0] wd, output bit [31:0] rd, output bit er);
        int     size;
        bit     legal;
        longint v;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        er    = !legal || ((a % size) != 0) || ((longint'(a) + size) > MEM_SIZE);
        rd    = 32'd0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < size; i++) mem_m[a + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v += longint'(mem_m[a + i]) << (8 * i);
                if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v -= longint'(1) << (8 * size);
                rd = v[31:0];
            end
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       resp_ready_a = ($urandom_range(0, 3) != 0);
            1:       resp_ready_a = 1'b0;
            default: resp_ready_a = 1'b1;
        endcase
    end

    // Present one request to instance A, predict its response once it is accepted.
    task automatic issue_a(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        bit        ok;
        bit [31:0] rd;
        bit        er;
        @(posedge clk); #1;
        req_write_a = wr; req_funct3_a = f3; req_addr_a = a; req_wdata_a = wd; req_valid_a = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (req_ready_a) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            note_timeout("accept_a");
            req_valid_a = 1'b0;
        end else begin
            model_access(wr, f3, a, wd, rd, er);
            q_a.push_back('{rd, er, cyc + 1});
            last_acc_a = cyc + 1;
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1) begin
                // Junk request while busy: must be ignored and must not overwrite captured fields.
                req_write_a = ~wr; req_funct3_a = 3'($urandom); req_addr_a = $urandom; req_wdata_a = $urandom;
                @(posedge clk); #1;
            end
            req_valid_a = 1'b0;
        end
    endtask

    task automatic drain_a();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (q_a.size() == 0 && !have_a && !resp_valid_a) begin done = 1'b1; break; end
        end
        if (!done) note_timeout("drain_a");
    endtask

    // Monitor: pops the expected response when a new one appears and checks it while held.
    always @(negedge clk) begin
        if (!rst_a && resp_valid_a) begin
            chk("req_ready_low_in_resp", 32'(req_ready_a), 32'd0);
            if (!have_a) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_resp: got a response, expected none (cycle %0d)", cyc);
                end else begin
                    cur_a  = q_a.pop_front();
                    have_a = 1'b1;
                    chk("resp_rdata", resp_rdata_a, cur_a.rd);
                    chk("resp_error", 32'(resp_error_a), 32'(cur_a.er));
                    chk("resp_latency", 32'(cyc - cur_a.acc), 32'(LAT_A));
                end
            end else begin
                chk("hold_rdata", resp_rdata_a, cur_a.rd);
                chk("hold_error", 32'(resp_error_a), 32'(cur_a.er));
            end
            if (resp_ready_a) begin
                have_a    = 1'b0;
                last_hs_a = cyc + 1;
            end
        end
    end

    task automatic b_issue(input bit wr, input bit [31:0] a, input bit [31:0] wd, output int acc);
        @(posedge clk); #1;
        req_write_b = wr; req_funct3_b = 3'd2; req_addr_b = a; req_wdata_b = wd; req_valid_b = 1'b1;
        acc = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready_b) begin acc = cyc + 1; break; end
        end
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        if (acc < 0) note_timeout("accept_b");
    endtask

    task automatic b_wait_resp(input int acc, input bit [31:0] exp_rd);
        int seen;
        seen = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (resp_valid_b) begin seen = cyc; break; end
        end
        if (seen < 0) begin
            note_timeout("resp_b");
        end else begin
            chk("b_latency", 32'(seen - acc), 32'(LAT_B));
            chk("b_rdata", resp_rdata_b, exp_rd);
            chk("b_error", 32'(resp_error_b), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] mask;
        int        acc;
        int        sel;

        rst_a = 1'b1; rst_b = 1'b1;
        req_valid_a = 1'b0; req_write_a = 1'b0; req_funct3_a = 3'd0; req_addr_a = 32'd0; req_wdata_a = 32'd0;
        req_valid_b = 1'b0; req_write_b = 1'b0; req_funct3_b = 3'd0; req_addr_b = 32'd0; req_wdata_b = 32'd0;
        resp_ready_a = 1'b1; resp_ready_b = 1'b1;

        repeat (3) @(negedge clk);
        req_valid_a = 1'b1;
        @(negedge clk);
        chk("rst_req_ready_a", 32'(req_ready_a), 32'd0);
        chk("rst_resp_valid_a", 32'(resp_valid_a), 32'd0);
        chk("rst_rdata_a", resp_rdata_a, 32'd0);
        chk("rst_error_a", 32'(resp_error_a), 32'd0);
        chk("rst_req_ready_b", 32'(req_ready_b), 32'd0);
        req_valid_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready_a", 32'(req_ready_a), 32'd1);
        chk("post_rst_resp_valid_a", 32'(resp_valid_a), 32'd0);
        chk("post_rst_req_ready_b", 32'(req_ready_b), 32'd1);

        // Establish a known-zero window and top-of-memory words.
        for (int w = 0; w < 64; w++) issue_a(1'b1, 3'd2, 32'(w * 4), 32'd0);
        issue_a(1'b1, 3'd2, MEM_SIZE - 8, 32'd0);
        issue_a(1'b1, 3'd2, MEM_SIZE - 4, 32'd0);
        drain_a();

        rr_mode = 0;
        issue_a(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        issue_a(1'b0, 3'd2, 32'h10, 32'h0);
        issue_a(1'b0, 3'd0, 32'h13, 32'h0);
        issue_a(1'b0, 3'd4, 32'h13, 32'h0);
        issue_a(1'b0, 3'd1, 32'h12, 32'h0);
        issue_a(1'b0, 3'd5, 32'h12, 32'h0);
        issue_a(1'b1, 3'd0, 32'h11, 32'h55);
        issue_a(1'b1, 3'd1, 32'h12, 32'h1234);
        issue_a(1'b0, 3'd2, 32'h10, 32'h0);
        issue_a(1'b0, 3'd2, 32'h12, 32'h0);
        issue_a(1'b1, 3'd1, 32'h11, 32'hFFFF);
        issue_a(1'b0, 3'd2, 32'h10, 32'h0);
        issue_a(1'b0, 3'd2, MEM_SIZE - 2, 32'h0);
        issue_a(1'b0, 3'd3, 32'h10, 32'h0);
        issue_a(1'b0, 3'd1, 32'hFFFFFFFE, 32'h0);
        issue_a(1'b1, 3'd0, MEM_SIZE - 1, 32'hA5);
        issue_a(1'b0, 3'd2, MEM_SIZE - 4, 32'h0);
        issue_a(1'b1, 3'd4, 32'h20, 32'h0);
        drain_a();

        // Backpressure: hold the response, park a second request, then release.
        @(negedge clk);
        rr_mode = 1;
        issue_a(1'b0, 3'd2, 32'h10, 32'h0);
        fork
            issue_a(1'b0, 3'd2, 32'h14, 32'h0);
            begin
                sel = 0;
                for (int t = 0; t < 20; t++) begin
                    if (resp_valid_a) begin sel = 1; break; end
                    @(negedge clk);
                end
                if (sel == 0) note_timeout("bp_resp");
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_req_ready", 32'(req_ready_a), 32'd0);
                    chk("bp_resp_valid", 32'(resp_valid_a), 32'd1);
                end
                rr_mode = 2;
            end
        join
        chk("bp_next_accept", 32'(last_acc_a), 32'(last_hs_a + 1));
        drain_a();

        rr_mode = 0;
        repeat (150) begin
            wr  = 1'($urandom_range(0, 1));
            f3  = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            if (!wr && f3 == 3'd0 && $urandom_range(0, 1) == 1) f3 = 3'd4;
            if (!wr && f3 == 3'd1 && $urandom_range(0, 1) == 1) f3 = 3'd5;
            sel = $urandom_range(0, 15);
            if (sel < 12)      a = 32'($urandom_range(0, 255));
            else if (sel < 15) a = MEM_SIZE - 32'($urandom_range(1, 8));
            else               a = $urandom;
            mask = ~((32'd1 << f3[1:0]) - 32'd1);
            if ($urandom_range(0, 3) != 0) a = a & mask;
            issue_a(wr, f3, a, $urandom);
        end
        rr_mode = 2;
        drain_a();

        // Reset while a store waits: it must never reach the array.
        b_issue(1'b1, 32'h20, 32'h0, acc);
        b_wait_resp(acc, 32'h0);
        b_issue(1'b1, 32'h20, 32'hCAFEF00D, acc);
        @(negedge clk);
        chk("abort_no_early_valid", 32'(resp_valid_b), 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_rst_resp_valid", 32'(resp_valid_b), 32'd0);
            chk("abort_rst_req_ready", 32'(req_ready_b), 32'd0);
            chk("abort_rst_rdata", resp_rdata_b, 32'd0);
        end
        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_post_resp_valid", 32'(resp_valid_b), 32'd0);
            chk("abort_post_req_ready", 32'(req_ready_b), 32'd1);
        end
        b_issue(1'b0, 32'h20, 32'h0, acc);
        b_wait_resp(acc, 32'h0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
